// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the read-slave state encoding.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        StIdle,
        StLocalWait,
        StResp
    } rd_slave_state_t;

endpackage

// File: rtl/axi4_lite_slave_read.sv
// AXI4-Lite read responder: decodes AR, fetches one word over a local req/vld port with a
// timeout, and returns it on R. One outstanding read at a time.
module axi4_lite_slave_read
    import axi4_lite_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        SIZE      = 4096,
    parameter int unsigned        TIMEOUT   = 16
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [2:0]        ARPROT,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              USR_RD_REQ,
    output logic [ADDR_W-1:0] USR_RD_ADDR,
    input  logic              USR_RD_VLD,
    input  logic [DATA_W-1:0] USR_RD_DATA,
    input  logic              USR_RD_ERR
);

    localparam int unsigned       CntW      = $clog2(TIMEOUT) + 1;
    localparam int unsigned       LsbW      = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'((1 << LsbW) - 1);
    localparam logic [ADDR_W:0]   SizeExt   = (ADDR_W + 1)'(SIZE);
    localparam logic [CntW-1:0]   CntLast   = CntW'(TIMEOUT - 1);

    rd_slave_state_t   state_q, state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    resp_t             rresp_q, rresp_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0] offset;
    logic              in_range;
    logic              ar_hs;
    logic              r_hs;
    logic              unused_arprot;

    assign unused_arprot = ^ARPROT;

    // Extra MSB on the compare keeps a window ending at the top of the address space legal.
    assign offset   = ARADDR - BASE_ADDR;
    assign in_range = (ARADDR >= BASE_ADDR) && ({1'b0, offset} < SizeExt);
    assign ar_hs    = ARVALID && arready_q;
    assign r_hs     = rvalid_q && RREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= StIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            req_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (ar_hs) state_d = in_range ? StLocalWait : StResp;
            StLocalWait: if (USR_RD_VLD || (cnt_q == CntLast)) state_d = StResp;
            StResp:      if (r_hs) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        req_d     = 1'b0;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                // Raises ARREADY on the first edge out of reset, drops it after a handshake.
                arready_d = !ar_hs;
                if (ar_hs) begin
                    cnt_d = '0;
                    if (in_range) begin
                        req_d  = 1'b1;
                        addr_d = offset & AlignMask;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = '0;
                        rresp_d  = DECERR;
                    end
                end
            end
            StLocalWait: begin
                if (USR_RD_VLD) begin
                    rvalid_d = 1'b1;
                    rdata_d  = USR_RD_DATA;
                    rresp_d  = USR_RD_ERR ? SLVERR : OKAY;
                end else if (cnt_q == CntLast) begin
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    rresp_d  = SLVERR;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (r_hs) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ARREADY     = arready_q;
    assign RVALID      = rvalid_q;
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign USR_RD_REQ  = req_q;
    assign USR_RD_ADDR = addr_q;

endmodule

// File: tb/tb_axi4_lite_slave_read.sv
// Directed bench for axi4_lite_slave_read: inputs change and outputs are sampled on the
// falling edge, so each negedge corresponds to one cycle after the preceding rising edge.
module tb_axi4_lite_slave_read;

    localparam int unsigned       AddrW   = 32;
    localparam int unsigned       DataW   = 32;
    localparam logic [AddrW-1:0]  Base    = 32'h0000_1000;
    localparam int unsigned       Size    = 4096;
    localparam int unsigned       Timeout = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             arvalid = 1'b0;
    logic             arready;
    logic [AddrW-1:0] araddr = '0;
    logic [2:0]       arprot = 3'b000;
    logic             rvalid;
    logic             rready = 1'b0;
    logic [DataW-1:0] rdata;
    logic [1:0]       rresp;
    logic             usr_req;
    logic [AddrW-1:0] usr_addr;
    logic             usr_vld = 1'b0;
    logic [DataW-1:0] usr_data = '0;
    logic             usr_err = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    axi4_lite_slave_read #(
        .ADDR_W   (AddrW),
        .DATA_W   (DataW),
        .BASE_ADDR(Base),
        .SIZE     (Size),
        .TIMEOUT  (Timeout)
    ) u_dut (
        .ACLK       (clk),
        .ARESETn    (rst_n),
        .ARVALID    (arvalid),
        .ARREADY    (arready),
        .ARADDR     (araddr),
        .ARPROT     (arprot),
        .RVALID     (rvalid),
        .RREADY     (rready),
        .RDATA      (rdata),
        .RRESP      (rresp),
        .USR_RD_REQ (usr_req),
        .USR_RD_ADDR(usr_addr),
        .USR_RD_VLD (usr_vld),
        .USR_RD_DATA(usr_data),
        .USR_RD_ERR (usr_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an address for one cycle; returns at the negedge of the cycle after the edge.
    task automatic ar_beat(input logic [AddrW-1:0] addr);
        arvalid = 1'b1;
        araddr  = addr;
        arprot  = addr[2:0];
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        check("rst_req", usr_req, 0);
        check("rst_addr", usr_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("arready_pre_edge", arready, 0);
        @(negedge clk);
        check("arready_after_rst", arready, 1);

        // Zero-wait read with VLD in the REQ cycle.
        rready = 1'b1;
        ar_beat(Base + 32'h10);
        check("t1_req", usr_req, 1);
        check("t1_addr", usr_addr, 32'h10);
        check("t1_arready_low", arready, 0);
        check("t1_rvalid_early", rvalid, 0);
        usr_vld  = 1'b1;
        usr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        usr_vld = 1'b0;
        check("t1_rvalid", rvalid, 1);
        check("t1_rdata", rdata, 32'hDEAD_BEEF);
        check("t1_rresp", rresp, 2'b00);
        check("t1_req_once", usr_req, 0);
        @(negedge clk);
        check("t1_rvalid_done", rvalid, 0);
        check("t1_arready_back", arready, 1);

        // Just past the window: DECERR with no local request.
        ar_beat(Base + Size);
        check("t2_req", usr_req, 0);
        check("t2_rvalid", rvalid, 1);
        check("t2_rresp", rresp, 2'b11);
        check("t2_rdata", rdata, 0);
        @(negedge clk);
        check("t2_done", rvalid, 0);
        @(negedge clk);

        // Just below the window.
        ar_beat(Base - 32'h4);
        check("t2b_req", usr_req, 0);
        check("t2b_rresp", rresp, 2'b11);
        @(negedge clk);
        @(negedge clk);

        // Last byte of the window, unaligned: offset is word-aligned.
        ar_beat(Base + Size - 1);
        check("t2c_req", usr_req, 1);
        check("t2c_addr", usr_addr, 32'hFFC);
        usr_vld  = 1'b1;
        usr_data = 32'h0BAD_F00D;
        @(negedge clk);
        usr_vld = 1'b0;
        check("t2c_rresp", rresp, 2'b00);
        check("t2c_rdata", rdata, 32'h0BAD_F00D);
        @(negedge clk);
        @(negedge clk);

        // Timeout: RVALID appears 16 cycles after the REQ cycle.
        rready = 1'b0;
        ar_beat(Base + 32'h40);
        check("t3_req", usr_req, 1);
        for (int i = 1; i < int'(Timeout); i++) begin
            @(negedge clk);
            check("t3_wait", rvalid, 0);
        end
        @(negedge clk);
        check("t3_rvalid", rvalid, 1);
        check("t3_rresp", rresp, 2'b10);
        check("t3_rdata", rdata, 0);
        usr_vld  = 1'b1;
        usr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("t3_stray_rdata", rdata, 0);
        check("t3_stray_rresp", rresp, 2'b10);
        rready = 1'b1;
        @(negedge clk);
        check("t3_done", rvalid, 0);
        @(negedge clk);
        check("t3_idle_vld_ignored", rvalid, 0);
        usr_vld = 1'b0;
        @(negedge clk);

        // VLD in the final counted cycle wins over the timeout.
        ar_beat(Base + 32'h44);
        for (int i = 1; i < int'(Timeout); i++) @(negedge clk);
        usr_vld  = 1'b1;
        usr_data = 32'h5555_AAAA;
        @(negedge clk);
        usr_vld = 1'b0;
        check("t3b_rvalid", rvalid, 1);
        check("t3b_rresp", rresp, 2'b00);
        check("t3b_rdata", rdata, 32'h5555_AAAA);
        @(negedge clk);
        @(negedge clk);

        // Local error with a one-cycle delay, then RREADY held low for 5 cycles.
        rready = 1'b0;
        ar_beat(Base + 32'h80);
        @(negedge clk);
        usr_vld  = 1'b1;
        usr_err  = 1'b1;
        usr_data = 32'h1234;
        @(negedge clk);
        usr_vld = 1'b0;
        usr_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t4_rvalid_hold", rvalid, 1);
            check("t4_rdata_hold", rdata, 32'h1234);
            check("t4_rresp_hold", rresp, 2'b10);
            check("t4_arready_low", arready, 0);
            @(negedge clk);
        end
        rready = 1'b1;
        check("t4_arready_pre_hs", arready, 0);
        @(negedge clk);
        check("t4_done", rvalid, 0);
        check("t4_arready_back", arready, 1);

        // Reset during LOCAL_WAIT: outputs clear at once, no R beat afterwards.
        ar_beat(Base + 32'hC0);
        check("t5_req", usr_req, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_req_clr", usr_req, 0);
        check("t5_addr_clr", usr_addr, 0);
        check("t5_arready_clr", arready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_no_rbeat", rvalid, 0);
        check("t5_arready", arready, 1);
        ar_beat(Base + 32'h20);
        check("t5_addr2", usr_addr, 32'h20);
        usr_vld  = 1'b1;
        usr_data = 32'hCAFE_F00D;
        @(negedge clk);
        usr_vld = 1'b0;
        check("t5_rdata2", rdata, 32'hCAFE_F00D);
        check("t5_rresp2", rresp, 2'b00);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
